// File: rtl/slot_ctrl_pkg.sv
// slot_ctrl_pkg: shared encodings and helpers for the slot controller
package slot_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_ARB   = 2'b01,
        ST_REPLY = 2'b10,
        ST_ACKED = 2'b11
    } state_e;

    localparam logic [2:0] CMD_QUERY = 3'b001;
    localparam logic [2:0] CMD_QREP  = 3'b010;
    localparam logic [2:0] CMD_QADJ  = 3'b011;
    localparam logic [2:0] CMD_ACK   = 3'b100;
    localparam logic [2:0] CMD_NAK   = 3'b101;

    localparam logic [2:0] UPDN_INC = 3'b110;
    localparam logic [2:0] UPDN_DEC = 3'b011;
    localparam logic [2:0] UPDN_NOP = 3'b000;

    localparam logic [14:0] SLOT_MAX = 15'h7FFF;

    function automatic logic [14:0] slot_mask(input logic [3:0] q);
        return 15'((16'd1 << q) - 16'd1);
    endfunction

    function automatic logic [3:0] q_adjust(input logic [3:0] q, input logic [2:0] updn);
        return (updn == UPDN_INC && q != 4'hF) ? q + 4'd1 :
               (updn == UPDN_DEC && q != 4'h0) ? q - 4'd1 : q;
    endfunction

endpackage

// File: rtl/slot_t2_tmr.sv
// slot_t2_tmr: reply-timeout counter, saturating at its last count so expiry persists
module slot_t2_tmr #(
    parameter int T2_CYC = 38
) (
    input  logic clk_1_92m,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(T2_CYC - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign cnt_d   = (en && cnt_q != LAST) ? cnt_q + 8'd1 : cnt_q;
    assign expired = en && cnt_q == LAST;

    // count cycles spent in REPLY, restarting on every entry
    always_ff @(posedge clk_1_92m) begin
        if (rst || clr) cnt_q <= 8'd0;
        else            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/slot_ctrl.sv
// slot_ctrl: tag inventory slot state machine with Q handling, RN16 draw and reply timeout
module slot_ctrl
    import slot_ctrl_pkg::*;
#(
    parameter int T2_CYC = 38
) (
    input  logic        clk_1_92m,
    input  logic        rst,
    input  logic [15:0] RNS,
    input  logic        CMD_VLD,
    input  logic [2:0]  CMD_TYPE,
    input  logic [3:0]  Q_IN,
    input  logic [2:0]  UPDN,
    input  logic [15:0] ACK_RN,
    output logic [1:0]  STATE,
    output logic [14:0] SLOT,
    output logic [3:0]  QCUR,
    output logic [15:0] RN16,
    output logic        REPLY_REQ,
    output logic        ACK_OK,
    output logic        ACK_ERR,
    output logic        TMO
);

    state_e      state_q, state_d;
    logic [14:0] slot_q, slot_d;
    logic [3:0]  q_q, q_d;
    logic [15:0] rn_q, rn_d;
    logic        req_q, req_d, ok_q, ok_d, err_q, err_d, tmo_q, tmo_d;
    logic        draw, expired, rn_match;
    logic [3:0]  q_new;
    logic [14:0] drawn_slot;

    assign q_new      = (CMD_TYPE == CMD_QUERY) ? Q_IN : q_adjust(q_q, UPDN);
    assign drawn_slot = RNS[14:0] & slot_mask(q_new);
    assign rn_match   = ACK_RN == rn_q;

    slot_t2_tmr #(.T2_CYC(T2_CYC)) u_t2 (
        .clk_1_92m (clk_1_92m),
        .rst       (rst),
        .clr       (req_d),
        .en        (state_q == ST_REPLY),
        .expired   (expired)
    );

    // command decode, slot draw and timeout handling
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        q_d     = q_q;
        rn_d    = rn_q;
        req_d   = 1'b0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        tmo_d   = 1'b0;
        draw    = 1'b0;
        if (CMD_VLD) begin
            case (CMD_TYPE)
                CMD_QUERY: draw = 1'b1;
                CMD_QREP: begin
                    if (state_q == ST_ARB) begin
                        slot_d  = slot_q - 15'd1;
                        req_d   = slot_q == 15'd1;
                        state_d = req_d ? ST_REPLY : ST_ARB;
                    end else if (state_q == ST_REPLY) begin
                        state_d = ST_ARB;
                        slot_d  = SLOT_MAX;
                    end else if (state_q == ST_ACKED) begin
                        state_d = ST_READY;
                    end
                end
                CMD_QADJ: begin
                    draw    = state_q == ST_ARB || state_q == ST_REPLY;
                    state_d = (state_q == ST_ACKED) ? ST_READY : state_q;
                end
                CMD_ACK: begin
                    if (state_q == ST_REPLY || state_q == ST_ACKED) begin
                        ok_d    = rn_match;
                        err_d   = !rn_match;
                        state_d = rn_match ? ST_ACKED : ST_ARB;
                        slot_d  = rn_match ? slot_q : SLOT_MAX;
                    end
                end
                CMD_NAK: begin
                    if (state_q != ST_READY) begin
                        state_d = ST_ARB;
                        slot_d  = SLOT_MAX;
                    end
                end
                default: ;
            endcase
        end else if (expired) begin
            state_d = ST_ARB;
            slot_d  = SLOT_MAX;
            tmo_d   = 1'b1;
        end
        if (draw) begin
            q_d     = q_new;
            rn_d    = RNS;
            slot_d  = drawn_slot;
            req_d   = drawn_slot == 15'd0;
            state_d = req_d ? ST_REPLY : ST_ARB;
        end
    end

    // register all state and status pulses
    always_ff @(posedge clk_1_92m) begin
        if (rst) begin
            state_q <= ST_READY;
            slot_q  <= 15'd0;
            q_q     <= 4'd0;
            rn_q    <= 16'd0;
            req_q   <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            q_q     <= q_d;
            rn_q    <= rn_d;
            req_q   <= req_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    assign STATE     = state_q;
    assign SLOT      = slot_q;
    assign QCUR      = q_q;
    assign RN16      = rn_q;
    assign REPLY_REQ = req_q;
    assign ACK_OK    = ok_q;
    assign ACK_ERR   = err_q;
    assign TMO       = tmo_q;

endmodule

// File: tb/tb_slot_ctrl.sv
// tb_slot_ctrl: directed self-checking bench for slot_ctrl
module tb_slot_ctrl;

    localparam int T2 = 38;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rns = 16'd0;
    logic        vld = 1'b0;
    logic [2:0]  typ = 3'd0;
    logic [3:0]  qin = 4'd0;
    logic [2:0]  updn = 3'd0;
    logic [15:0] ack_rn = 16'd0;
    logic [1:0]  state;
    logic [14:0] slot;
    logic [3:0]  qcur;
    logic [15:0] rn16;
    logic        req, ok, err, tmo;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        seen;

    always #5 clk = ~clk;

    slot_ctrl #(.T2_CYC(T2)) dut (
        .clk_1_92m (clk),
        .rst       (rst),
        .RNS       (rns),
        .CMD_VLD   (vld),
        .CMD_TYPE  (typ),
        .Q_IN      (qin),
        .UPDN      (updn),
        .ACK_RN    (ack_rn),
        .STATE     (state),
        .SLOT      (slot),
        .QCUR      (qcur),
        .RN16      (rn16),
        .REPLY_REQ (req),
        .ACK_OK    (ok),
        .ACK_ERR   (err),
        .TMO       (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // drive one command for one cycle; returns at the negedge after it took effect
    task automatic send(input logic [2:0] t, input logic [3:0] q, input logic [2:0] ud,
                        input logic [15:0] a, input logic [15:0] r);
        @(negedge clk);
        vld = 1'b1; typ = t; qin = q; updn = ud; ack_rn = a; rns = r;
        @(negedge clk);
        vld = 1'b0;
    endtask

    task automatic chk_pulses(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, req, ok, err, tmo}, {28'd0, exp});
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_slot", slot, 0);
        chk("rst_q", qcur, 0);
        chk("rst_rn", rn16, 0);
        chk_pulses("rst_pulses", 4'b0000);

        send(3'b001, 4'd4, 3'd0, 16'd0, 16'hA5C3);
        chk("q4_slot", slot, 3);
        chk("q4_rn", rn16, 16'hA5C3);
        chk("q4_state", state, 1);
        chk("q4_q", qcur, 4);
        send(3'b010, 0, 0, 0, 16'h1111);
        chk("rep1_slot", slot, 2);
        chk_pulses("rep1_pulses", 4'b0000);
        send(3'b010, 0, 0, 0, 0);
        chk("rep2_slot", slot, 1);
        send(3'b010, 0, 0, 0, 0);
        chk("rep3_slot", slot, 0);
        chk("rep3_state", state, 2);
        chk_pulses("rep3_req", 4'b1000);
        chk("rep3_rn_kept", rn16, 16'hA5C3);
        tick();
        chk_pulses("rep3_req_once", 4'b0000);

        send(3'b001, 4'd0, 0, 0, 16'hBEEF);
        chk("q0_state", state, 2);
        chk("q0_slot", slot, 0);
        chk_pulses("q0_req", 4'b1000);

        send(3'b001, 4'd0, 0, 0, 16'h1234);
        send(3'b100, 0, 0, 16'h1234, 0);
        chk("ack_ok_state", state, 3);
        chk_pulses("ack_ok_pulse", 4'b0100);
        send(3'b100, 0, 0, 16'h1235, 0);
        chk("ack_err_state", state, 1);
        chk("ack_err_slot", slot, 15'h7FFF);
        chk_pulses("ack_err_pulse", 4'b0010);

        send(3'b001, 4'd0, 0, 0, 16'h00AA);
        send(3'b100, 0, 0, 16'h00AA, 0);
        send(3'b010, 0, 0, 0, 0);
        chk("rep_acked_ready", state, 0);
        send(3'b010, 0, 0, 0, 0);
        chk("rep_ready_ign", state, 0);
        chk_pulses("rep_ready_pulses", 4'b0000);

        send(3'b001, 4'd15, 0, 0, 16'hFFFF);
        send(3'b011, 0, 3'b110, 0, 16'hFFFF);
        chk("qadj_up_q", qcur, 15);
        chk("qadj_up_slot", slot, 15'h7FFF);
        chk("qadj_up_state", state, 1);
        send(3'b001, 4'd0, 0, 0, 16'h0042);
        send(3'b011, 0, 3'b011, 0, 16'h5555);
        chk("qadj_dn_q", qcur, 0);
        chk("qadj_dn_state", state, 2);
        chk("qadj_dn_rn", rn16, 16'h5555);
        chk_pulses("qadj_dn_req", 4'b1000);

        seen = 1'b0;
        for (int i = 1; i < T2; i++) begin
            tick();
            seen |= tmo;
        end
        chk("tmo_early", seen, 0);
        chk("tmo_pre_state", state, 2);
        tick();
        chk_pulses("tmo_pulse", 4'b0001);
        chk("tmo_state", state, 1);
        chk("tmo_slot", slot, 15'h7FFF);
        tick();
        chk("tmo_once", tmo, 0);

        send(3'b001, 4'd0, 0, 0, 16'h0F0F);
        seen = 1'b0;
        for (int i = 0; i < T2 - 2; i++) begin
            tick();
            seen |= tmo;
        end
        send(3'b010, 0, 0, 0, 0);
        seen |= tmo;
        chk("tmo_prio_state", state, 1);
        chk("tmo_prio_slot", slot, 15'h7FFF);
        tick();
        seen |= tmo;
        chk("tmo_prio_none", seen, 0);

        send(3'b010, 0, 0, 0, 0);
        chk("wrap_dec", slot, 15'h7FFE);
        send(3'b101, 0, 0, 0, 0);
        chk("nak_slot", slot, 15'h7FFF);
        send(3'b100, 0, 0, 16'h0F0F, 0);
        chk("ack_arb_state", state, 1);
        chk_pulses("ack_arb_pulses", 4'b0000);

        send(3'b001, 4'd0, 0, 0, 16'h7777);
        @(negedge clk);
        rst = 1'b1; vld = 1'b1; typ = 3'b100; ack_rn = 16'h7777;
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;
        chk("rst_mid_state", state, 0);
        chk("rst_mid_outs", {slot, qcur, rn16}, 0);
        chk_pulses("rst_mid_pulses", 4'b0000);
        seen = 1'b0;
        for (int i = 0; i < T2 + 4; i++) begin
            tick();
            seen |= tmo;
        end
        chk("rst_no_tmo", seen, 0);
        chk("rst_stay_ready", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
